// File: rtl/score_generator_pkg.sv
// Shared constants and state encoding for the score generator and its level tracker.
package score_generator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [15:0] SCORE_1   = 16'd40;
    localparam logic [15:0] SCORE_2   = 16'd100;
    localparam logic [15:0] SCORE_3   = 16'd300;
    localparam logic [15:0] SCORE_4   = 16'd1200;
    localparam logic [9:0]  LINES_SAT = 10'd999;

    function automatic logic [15:0] base_score(input logic [2:0] rows);
        case (rows)
            3'd1:    return SCORE_1;
            3'd2:    return SCORE_2;
            3'd3:    return SCORE_3;
            3'd4:    return SCORE_4;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/score_level_tracker.sv
// Tracks total cleared rows, rows within the current level, and the level itself.
// One add strobe per scored clear; at most one level step per strobe.
module score_level_tracker
    import score_generator_pkg::*;
#(
    parameter int START_LEVEL     = 0,
    parameter int MAX_LEVEL       = 29,
    parameter int LINES_PER_LEVEL = 10
) (
    input  logic       clk_25_175,
    input  logic       reset,
    input  logic       new_game,
    input  logic       i_add,
    input  logic [2:0] i_rows,
    output logic [4:0] o_level,
    output logic [9:0] o_lines_total,
    output logic       o_level_up
);

    logic [4:0]  r_level;
    logic [9:0]  r_lines_total;
    logic [3:0]  r_lines_in_level;
    logic        r_level_up;

    logic [10:0] w_total_sum;
    logic [9:0]  w_total_next;
    logic [4:0]  w_lil_sum;
    logic        w_roll;
    logic [3:0]  w_lil_next;

    assign w_total_sum  = {1'b0, r_lines_total} + {8'd0, i_rows};
    assign w_total_next = (w_total_sum > {1'b0, LINES_SAT}) ? LINES_SAT : w_total_sum[9:0];
    assign w_lil_sum    = {1'b0, r_lines_in_level} + {2'd0, i_rows};
    assign w_roll       = (w_lil_sum >= 5'(LINES_PER_LEVEL));
    assign w_lil_next   = w_roll ? 4'(w_lil_sum - 5'(LINES_PER_LEVEL)) : w_lil_sum[3:0];

    always_ff @(posedge clk_25_175) begin
        if (!reset || new_game) begin
            r_level          <= 5'(START_LEVEL);
            r_lines_total    <= 10'd0;
            r_lines_in_level <= 4'd0;
            r_level_up       <= 1'b0;
        end else begin
            r_level_up <= 1'b0;
            if (i_add) begin
                r_lines_total    <= w_total_next;
                r_lines_in_level <= w_lil_next;
                // Rows keep rolling over at max level; only the level saturates.
                if (w_roll && (r_level < 5'(MAX_LEVEL))) begin
                    r_level    <= r_level + 5'd1;
                    r_level_up <= 1'b1;
                end
            end
        end
    end

    assign o_level       = r_level;
    assign o_lines_total = r_lines_total;
    assign o_level_up    = r_level_up;

endmodule

// File: rtl/score_generator.sv
// Turns line-clear and soft-drop events into one-cycle scorewire add pulses.
// Clear awards use a sequential multiply of the base score by (level+1).
module score_generator
    import score_generator_pkg::*;
#(
    parameter int START_LEVEL     = 0,
    parameter int MAX_LEVEL       = 29,
    parameter int LINES_PER_LEVEL = 10
) (
    input  logic        clk_25_175,
    input  logic        reset,
    input  logic        new_game,
    input  logic        game_over,
    input  logic        clear_valid,
    input  logic [2:0]  clear_lines,
    output logic        clear_ready,
    input  logic        drop_pulse,
    output logic [15:0] scorewire,
    output logic [4:0]  level,
    output logic [9:0]  lines_total,
    output logic        level_up
);

    state_t      r_state;
    logic [15:0] r_base;
    logic [2:0]  r_rows;
    logic [4:0]  r_cnt;
    logic [15:0] r_acc;
    logic [7:0]  r_pending;
    logic        r_drop_seen;
    logic [15:0] r_scorewire;

    logic        w_accept;
    logic        w_legal;
    logic        w_drop_inc;
    logic        w_mult_done;
    logic        w_drop_emit;
    logic [15:0] w_acc_next;
    logic [7:0]  w_pending_inc;

    assign clear_ready   = (r_state == IDLE) && !game_over;
    assign w_accept      = clear_valid && clear_ready;
    assign w_legal       = (clear_lines != 3'd0) && (clear_lines <= 3'd4);
    assign w_drop_inc    = drop_pulse && !game_over;
    assign w_mult_done   = (r_state == MULT) && (r_cnt == 5'd0);
    assign w_acc_next    = r_acc + r_base;
    assign w_pending_inc = (r_pending == 8'hFF) ? r_pending : r_pending + 8'd1;

    // Drop points go out once a burst of drop pulses has ended, in a slot that
    // cannot carry a clear award (IDLE without acceptance, or the EMIT cycle).
    assign w_drop_emit = (((r_state == IDLE) && !w_accept) || (r_state == EMIT))
                         && (r_pending != 8'd0) && !r_drop_seen;

    always_ff @(posedge clk_25_175) begin
        if (!reset || new_game) begin
            r_state     <= IDLE;
            r_base      <= 16'd0;
            r_rows      <= 3'd0;
            r_cnt       <= 5'd0;
            r_acc       <= 16'd0;
            r_pending   <= 8'd0;
            r_drop_seen <= 1'b0;
            r_scorewire <= 16'd0;
        end else begin
            r_scorewire <= 16'd0;
            r_drop_seen <= w_drop_inc;

            if (w_drop_emit) begin
                r_scorewire <= {8'd0, r_pending};
                r_pending   <= {7'd0, w_drop_inc};
            end else if (w_drop_inc) begin
                r_pending <= w_pending_inc;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept && w_legal) begin
                        r_base  <= base_score(clear_lines);
                        r_rows  <= clear_lines;
                        r_cnt   <= level;
                        r_acc   <= 16'd0;
                        r_state <= MULT;
                    end
                end
                MULT: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == 5'd0) begin
                        r_scorewire <= w_acc_next;
                        r_state     <= EMIT;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                EMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    score_level_tracker #(
        .START_LEVEL    (START_LEVEL),
        .MAX_LEVEL      (MAX_LEVEL),
        .LINES_PER_LEVEL(LINES_PER_LEVEL)
    ) u_tracker (
        .clk_25_175   (clk_25_175),
        .reset        (reset),
        .new_game     (new_game),
        .i_add        (w_mult_done),
        .i_rows       (r_rows),
        .o_level      (level),
        .o_lines_total(lines_total),
        .o_level_up   (level_up)
    );

    assign scorewire = r_scorewire;

endmodule

// File: tb/tb_score_generator.sv
// Scoreboard bench for score_generator: stimulus pushes expected awards, a negedge monitor pops them.
module tb_score_generator;

    logic        clk_25_175 = 1'b0;
    logic        reset = 1'b0;
    logic        new_game = 1'b0;
    logic        game_over = 1'b0;
    logic        clear_valid = 1'b0;
    logic [2:0]  clear_lines = 3'd0;
    logic        clear_ready;
    logic        drop_pulse = 1'b0;
    logic [15:0] scorewire;
    logic [4:0]  level;
    logic [9:0]  lines_total;
    logic        level_up;

    typedef struct {
        int val;
        bit lu;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int m_level = 0;
    int m_lines = 0;
    int m_lil = 0;

    score_generator dut (
        .clk_25_175 (clk_25_175),
        .reset      (reset),
        .new_game   (new_game),
        .game_over  (game_over),
        .clear_valid(clear_valid),
        .clear_lines(clear_lines),
        .clear_ready(clear_ready),
        .drop_pulse (drop_pulse),
        .scorewire  (scorewire),
        .level      (level),
        .lines_total(lines_total),
        .level_up   (level_up)
    );

    always #5 clk_25_175 = ~clk_25_175;
    always @(posedge clk_25_175) cyc <= cyc + 1;

    always @(negedge clk_25_175) begin
        exp_t e;
        if (scorewire != 16'd0 || level_up) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_award cyc %0d got %0d level_up %0d", cyc, scorewire, level_up);
            end else begin
                e = sb.pop_front();
                if (scorewire != 16'(e.val) || level_up != e.lu || (e.cyc >= 0 && e.cyc != cyc)) begin
                    errors++;
                    $display("FAIL award cyc %0d got %0d lu %0d, expected %0d lu %0d at cyc %0d",
                             cyc, scorewire, level_up, e.val, e.lu, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_25_175);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int award(input int n);
        case (n)
            1: return 40 * (m_level + 1);
            2: return 100 * (m_level + 1);
            3: return 300 * (m_level + 1);
            4: return 1200 * (m_level + 1);
            default: return 0;
        endcase
    endfunction

    task automatic model_update(input int n, output bit lu);
        lu = 1'b0;
        m_lines = (m_lines + n > 999) ? 999 : m_lines + n;
        m_lil += n;
        if (m_lil >= 10) begin
            m_lil -= 10;
            if (m_level < 29) begin
                m_level++;
                lu = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_level = 0;
        m_lines = 0;
        m_lil   = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!clear_ready && n < 200) begin
            step();
            n++;
        end
        if (!clear_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got %0d expected 1", clear_ready);
        end
    endtask

    task automatic do_clear(input int n, input int exp_award);
        int  t;
        int  lvl;
        bit  lu;
        exp_t e;
        wait_ready();
        clear_valid = 1'b1;
        clear_lines = 3'(n);
        t   = cyc;
        lvl = m_level;
        model_update(n, lu);
        e.val = exp_award;
        e.lu  = lu;
        e.cyc = t + lvl + 2;
        sb.push_back(e);
        step();
        clear_valid = 1'b0;
        for (int i = 0; i <= lvl + 1; i++) begin
            chk("busy_ready", int'(clear_ready), 0);
            step();
        end
        chk("ready_after", int'(clear_ready), 1);
    endtask

    task automatic abort_mid_mult(input bit use_reset);
        while (m_level < 20) do_clear(4, award(4));
        wait_ready();
        clear_valid = 1'b1;
        clear_lines = 3'd3;
        step();
        clear_valid = 1'b0;
        repeat (4) step();
        if (use_reset) reset = 1'b0;
        else new_game = 1'b1;
        step();
        reset = 1'b1;
        new_game = 1'b0;
        model_reset();
        chk("abort_level", int'(level), 0);
        chk("abort_lines", int'(lines_total), 0);
        chk("abort_ready", int'(clear_ready), 1);
        chk("abort_score", int'(scorewire), 0);
        repeat (30) step();
    endtask

    initial begin
        exp_t e;
        int t;

        repeat (3) step();
        chk("rst_score", int'(scorewire), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_lines", int'(lines_total), 0);
        chk("rst_level_up", int'(level_up), 0);
        chk("rst_ready", int'(clear_ready), 1);
        reset = 1'b1;
        step();

        // single row at level 0
        do_clear(1, 40);
        chk("single_lines", int'(lines_total), 1);
        chk("single_level", int'(level), 0);

        // illegal row counts are accepted and discarded
        clear_valid = 1'b1;
        clear_lines = 3'd0;
        step();
        chk("zero_ready", int'(clear_ready), 1);
        clear_lines = 3'd5;
        step();
        clear_valid = 1'b0;
        repeat (5) step();
        chk("zero_lines", int'(lines_total), 1);

        // soft drops
        for (int i = 0; i < 3; i++) begin
            drop_pulse = 1'b1;
            step();
        end
        drop_pulse = 1'b0;
        e.val = 3; e.lu = 1'b0; e.cyc = -1;
        sb.push_back(e);
        repeat (6) step();
        for (int i = 0; i < 300; i++) begin
            drop_pulse = 1'b1;
            step();
        end
        drop_pulse = 1'b0;
        e.val = 255; e.lu = 1'b0; e.cyc = -1;
        sb.push_back(e);
        repeat (6) step();

        // clear accepted while 5 drop points are pending
        for (int i = 0; i < 5; i++) begin
            drop_pulse = 1'b1;
            step();
        end
        drop_pulse = 1'b0;
        clear_valid = 1'b1;
        clear_lines = 3'd2;
        t = cyc;
        e.val = 100; e.lu = 1'b0; e.cyc = t + 2;
        sb.push_back(e);
        e.val = 5; e.lu = 1'b0; e.cyc = t + 3;
        sb.push_back(e);
        step();
        clear_valid = 1'b0;
        repeat (6) step();
        chk("mix_lines", int'(lines_total), 3);

        // restart, then ten single clears for a level step
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_reset();
        chk("ng_level", int'(level), 0);
        chk("ng_lines", int'(lines_total), 0);
        for (int i = 0; i < 10; i++) do_clear(1, 40);
        chk("ten_level", int'(level), 1);
        do_clear(1, 80);
        chk("eleven_lines", int'(lines_total), 11);

        // four rows at level 9
        while (m_level < 9) do_clear(1, award(1));
        chk("lvl9_level", int'(level), 9);
        do_clear(4, 12000);

        abort_mid_mult(1'b1);
        abort_mid_mult(1'b0);

        // game over freezes new input
        game_over = 1'b1;
        step();
        chk("go_ready", int'(clear_ready), 0);
        clear_valid = 1'b1;
        clear_lines = 3'd1;
        for (int i = 0; i < 5; i++) begin
            drop_pulse = 1'b1;
            step();
        end
        clear_valid = 1'b0;
        drop_pulse = 1'b0;
        repeat (5) step();
        game_over = 1'b0;
        step();
        chk("go_lines", int'(lines_total), 0);
        chk("go_ready_after", int'(clear_ready), 1);

        // saturation of lines and level
        while (m_lines < 999) do_clear(4, award(4));
        chk("sat_lines", int'(lines_total), 999);
        chk("sat_level", int'(level), 29);

        repeat (10) step();
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
